game_ctrl: RTL and testbench

Top-level game sequencer for the 800x600 brick-smasher display. Watches the pixel stream for ball/bottom-wall overlap, runs the serve / play / pause / miss / game-over / win state machine, and tracks lives and score. It gates ball motion, re-serves the ball, and drives a flash request that makes the bottom wall blink after a miss. It sits beside the object generators (ball, paddle, bricks, wall) and feeds the RGB mux and the score/lives overlay.

---
 rtl/game_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// game_ctrl -- brick-smasher game sequencer.
// Watches the pixel stream for ball/bottom-wall overlap, runs the
// IDLE/SERVE/PLAY/PAUSE/MISS/OVER/WIN state machine, and tracks lives
// and a saturating score.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   refr_tick         one-cycle pulse per frame (first blanking pixel)
//   ball_on, wall_on  pixel-in-object flags
//   brick_hit         one-cycle pulse per destroyed brick
//   bricks_clear      level, no bricks left
//   btn_start/pause   one-cycle button pulses
//   game_state        0 IDLE,1 SERVE,2 PLAY,3 PAUSE,4 MISS,5 OVER,6 WIN
//   ball_run          ball may move (PLAY only)
//   ball_rst          pulse on first SERVE cycle
//   wall_alert        bottom-wall flash request during MISS
//   lives, score      remaining lives, binary score
module game_ctrl #(
  parameter int LIVES        = 3,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 30,
  parameter int FLASH_SHIFT  = 2,
  parameter int BRICK_POINTS = 10,
  parameter int SCORE_MAX    = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        refr_tick,
  input  logic        ball_on,
  input  logic        wall_on,
  input  logic        brick_hit,
  input  logic        bricks_clear,
  input  logic        btn_start,
  input  logic        btn_pause,
  output logic [2:0]  game_state,
  output logic        ball_run,
  output logic        ball_rst,
  output logic        wall_alert,
  output logic [1:0]  lives,
  output logic [13:0] score
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    MISS  = 3'd4,
    OVER  = 3'd5,
    WIN   = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  frame_cnt_q, frame_cnt_d;
  logic        miss_q, miss_d;
  logic [1:0]  lives_q, lives_d;
  logic [13:0] score_q, score_d;
  logic        ball_run_q, ball_run_d;
  logic        ball_rst_q, ball_rst_d;
  logic        wall_alert_q, wall_alert_d;
  logic [14:0] score_sum;

  assign score_sum = {1'b0, score_q} + 15'(BRICK_POINTS);

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    miss_d      = miss_q;
    lives_d     = lives_q;
    score_d     = score_q;

    case (state_q)
      IDLE, OVER, WIN: begin
        if (btn_start) begin
          state_d = SERVE;
          lives_d = 2'(LIVES);
          score_d = '0;
        end
      end
      SERVE: begin
        if (refr_tick && frame_cnt_q == 7'(SERVE_FRAMES - 1)) state_d = PLAY;
      end
      PLAY: begin
        // Frame evaluation takes precedence over a same-cycle pause.
        if (refr_tick) begin
          if (bricks_clear) begin
            state_d = WIN;
          end else if (miss_q) begin
            state_d = MISS;
            lives_d = lives_q - 2'd1;
          end
        end else if (btn_pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (btn_pause) state_d = PLAY;
      end
      MISS: begin
        if (refr_tick && frame_cnt_q == 7'(MISS_FRAMES - 1))
          state_d = (lives_q == 2'd0) ? OVER : SERVE;
      end
      default: state_d = IDLE;
    endcase

    // Overlap is latched during the frame and consumed at the tick.
    if (state_q == PLAY) begin
      if (refr_tick)                 miss_d = 1'b0;
      else if (ball_on && wall_on)   miss_d = 1'b1;
    end
    if (state_d == SERVE && state_q != SERVE) miss_d = 1'b0;

    // Hit on the tick that leaves PLAY still counts (uses current state).
    if (state_q == PLAY && brick_hit)
      score_d = (score_sum > 15'(SCORE_MAX)) ? 14'(SCORE_MAX) : score_sum[13:0];

    if (state_d != state_q)
      frame_cnt_d = '0;
    else if (refr_tick && (state_q == SERVE || state_q == MISS))
      frame_cnt_d = frame_cnt_q + 7'd1;

    // Outputs registered from next-state values so they align with game_state.
    ball_run_d   = (state_d == PLAY);
    ball_rst_d   = (state_d == SERVE) && (state_q != SERVE);
    wall_alert_d = (state_d == MISS) && frame_cnt_d[FLASH_SHIFT];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      frame_cnt_q  <= '0;
      miss_q       <= 1'b0;
      lives_q      <= 2'(LIVES);
      score_q      <= '0;
      ball_run_q   <= 1'b0;
      ball_rst_q   <= 1'b0;
      wall_alert_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      miss_q       <= miss_d;
      lives_q      <= lives_d;
      score_q      <= score_d;
      ball_run_q   <= ball_run_d;
      ball_rst_q   <= ball_rst_d;
      wall_alert_q <= wall_alert_d;
    end
  end

  assign game_state = state_q;
  assign ball_run   = ball_run_q;
  assign ball_rst   = ball_rst_q;
  assign wall_alert = wall_alert_q;
  assign lives      = lives_q;
  assign score      = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters.
module tb_game_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        refr_tick = 1'b0, ball_on = 1'b0, wall_on = 1'b0;
  logic        brick_hit = 1'b0, bricks_clear = 1'b0;
  logic        btn_start = 1'b0, btn_pause = 1'b0;
  logic [2:0]  game_state;
  logic        ball_run, ball_rst, wall_alert;
  logic [1:0]  lives;
  logic [13:0] score;

  int vectors = 0;
  int miscompares = 0;

  game_ctrl dut (
    .clk(clk), .rst_n(rst_n), .refr_tick(refr_tick), .ball_on(ball_on),
    .wall_on(wall_on), .brick_hit(brick_hit), .bricks_clear(bricks_clear),
    .btn_start(btn_start), .btn_pause(btn_pause), .game_state(game_state),
    .ball_run(ball_run), .ball_rst(ball_rst), .wall_alert(wall_alert),
    .lives(lives), .score(score)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given single-cycle inputs; sample #1 after the edge.
  task automatic step(input logic tk, input logic bh, input logic st,
                      input logic ps, input logic ov);
    refr_tick = tk; brick_hit = bh; btn_start = st; btn_pause = ps;
    ball_on = ov; wall_on = ov;
    @(posedge clk); #1;
    refr_tick = 0; brick_hit = 0; btn_start = 0; btn_pause = 0;
    ball_on = 0; wall_on = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", game_state, 0);
    chk("rst_lives", lives, 3);
    chk("rst_score", score, 0);
    chk("rst_run", ball_run, 0);
    chk("rst_brst", ball_rst, 0);
    chk("rst_alert", wall_alert, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // Pause ignored in IDLE, then start
    step(0, 0, 0, 1, 0);
    chk("idle_pause", game_state, 0);
    step(0, 0, 1, 0, 0);
    chk("start_state", game_state, 1);
    chk("start_brst", ball_rst, 1);
    chk("start_lives", lives, 3);
    step(0, 0, 0, 0, 0);
    chk("brst_one_cycle", ball_rst, 0);
    step(0, 0, 1, 1, 0);
    chk("serve_btn_ign", game_state, 1);

    // SERVE lasts exactly 60 ticks
    ticks(59);
    chk("serve_59", game_state, 1);
    chk("serve_run0", ball_run, 0);
    step(1, 0, 0, 0, 0);
    chk("play_state", game_state, 2);
    chk("play_run", ball_run, 1);

    // Scoring in PLAY
    repeat (3) step(0, 1, 0, 0, 0);
    chk("score_30", score, 30);

    // Miss #1: overlap then tick (with a same-cycle hit that still scores)
    step(0, 0, 0, 0, 1);
    chk("overlap_no_miss_yet", game_state, 2);
    step(1, 1, 0, 0, 0);
    chk("miss_state", game_state, 4);
    chk("miss_lives", lives, 2);
    chk("miss_hit_scored", score, 40);
    chk("miss_run", ball_run, 0);
    chk("alert_cnt0", wall_alert, 0);
    ticks(3);
    chk("alert_cnt3", wall_alert, 0);
    ticks(1);
    chk("alert_cnt4", wall_alert, 1);
    ticks(3);
    chk("alert_cnt7", wall_alert, 1);
    ticks(1);
    chk("alert_cnt8", wall_alert, 0);
    ticks(21);
    chk("miss_29", game_state, 4);
    step(1, 0, 0, 0, 0);
    chk("reserve_state", game_state, 1);
    chk("reserve_brst", ball_rst, 1);
    ticks(60);
    chk("play2", game_state, 2);

    // Pause: hits and overlap ignored, no evaluation
    step(0, 0, 0, 1, 0);
    chk("pause_state", game_state, 3);
    chk("pause_run", ball_run, 0);
    step(0, 1, 0, 0, 0);
    chk("pause_score", score, 40);
    step(0, 0, 0, 0, 1);
    ticks(3);
    chk("pause_no_miss", game_state, 3);
    step(0, 0, 1, 0, 0);
    chk("pause_start_ign", game_state, 3);
    step(0, 0, 0, 1, 0);
    chk("resume", game_state, 2);
    ticks(1);
    chk("resume_no_miss", game_state, 2);
    step(1, 0, 0, 1, 0);
    chk("tick_beats_pause", game_state, 2);

    // Misses #2 and #3 -> OVER
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("miss2_lives", lives, 1);
    ticks(30);
    chk("miss2_serve", game_state, 1);
    ticks(60);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("miss3_state", game_state, 4);
    chk("miss3_lives", lives, 0);
    ticks(30);
    chk("over_state", game_state, 5);
    chk("over_lives", lives, 0);
    chk("over_brst", ball_rst, 0);
    step(0, 0, 1, 0, 0);
    chk("restart_state", game_state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);

    // Saturating score
    ticks(60);
    repeat (999) step(0, 1, 0, 0, 0);
    chk("score_9990", score, 9990);
    step(0, 1, 0, 0, 0);
    chk("score_sat", score, 9999);
    step(0, 1, 0, 0, 0);
    chk("score_sat_hold", score, 9999);

    // Win beats miss in same frame
    bricks_clear = 1'b1;
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    bricks_clear = 1'b0;
    chk("win_state", game_state, 6);
    chk("win_lives", lives, 3);
    step(0, 0, 1, 0, 0);
    chk("win_restart", game_state, 1);

    // Async reset mid-PLAY
    ticks(60);
    repeat (2) step(0, 1, 0, 0, 0);
    chk("pre_rst_score", score, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("async_state", game_state, 0);
    chk("async_score", score, 0);
    chk("async_run", ball_run, 0);
    chk("async_lives", lives, 3);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
